// File: rtl/mem_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_cmd_arbiter
// Description : Round-robin merge of two memory command streams onto one
//               registered DDR command port, with in-order read-data routing.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_cmd_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int BE_WIDTH       = 64,
    parameter int RD_OUTSTANDING = 8
) (
    input  logic                                  clk_core,
    input  logic                                  rst,
    input  logic [1:0]                            s_cmd_valid,
    output logic [1:0]                            s_cmd_ready,
    input  logic [2*ADDR_WIDTH-1:0]               s_cmd_addr,
    input  logic [1:0]                            s_cmd_rd_wrn,
    input  logic [2*BE_WIDTH-1:0]                 s_cmd_be,
    input  logic [2*DATA_WIDTH-1:0]               s_cmd_wdata,
    output logic [1:0]                            s_rd_valid,
    input  logic [1:0]                            s_rd_ready,
    output logic [DATA_WIDTH-1:0]                 s_rd_data,
    output logic                                  m_cmd_valid,
    input  logic                                  m_cmd_ready,
    output logic [ADDR_WIDTH-1:0]                 m_cmd_addr,
    output logic                                  m_cmd_rd_wrn,
    output logic [BE_WIDTH-1:0]                   m_cmd_be,
    output logic [DATA_WIDTH-1:0]                 m_cmd_wdata,
    input  logic                                  m_rd_valid,
    output logic                                  m_rd_ready,
    input  logic [DATA_WIDTH-1:0]                 m_rd_data,
    output logic [$clog2(RD_OUTSTANDING+1)-1:0]   o_rd_outstanding,
    output logic                                  o_err_unexp_rd
);

    localparam int c_idx_w = $clog2(RD_OUTSTANDING);
    localparam int c_ptr_w = c_idx_w + 1;
    localparam int c_cnt_w = $clog2(RD_OUTSTANDING + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic                   r_cmd_valid;
    logic [ADDR_WIDTH-1:0]  r_cmd_addr;
    logic                   r_cmd_rd_wrn;
    logic [BE_WIDTH-1:0]    r_cmd_be;
    logic [DATA_WIDTH-1:0]  r_cmd_wdata;
    logic                   r_last_grant;
    logic                   r_err_unexp_rd;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic                   r_tag_mem [RD_OUTSTANDING];

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                   w_out_free;
    logic                   w_empty;
    logic                   w_full;
    logic [c_ptr_w-1:0]     w_count;
    logic [1:0]             w_elig;
    logic [1:0]             w_grant;
    logic                   w_accept;
    logic                   w_sel;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_head;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic                   w_sel_rd_wrn;
    logic [BE_WIDTH-1:0]    w_sel_be;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                     (r_wr_ptr[c_idx_w-1:0] == r_rd_ptr[c_idx_w-1:0]);
    assign w_count = r_wr_ptr - r_rd_ptr;

    assign w_out_free = !r_cmd_valid || m_cmd_ready;

    // A read is held off while the tag FIFO is full, even if a pop is in flight.
    assign w_elig[0] = s_cmd_valid[0] && (!s_cmd_rd_wrn[0] || !w_full);
    assign w_elig[1] = s_cmd_valid[1] && (!s_cmd_rd_wrn[1] || !w_full);

    always_comb begin
        w_grant = 2'b00;
        if (w_out_free) begin
            case (w_elig)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign s_cmd_ready = w_grant;
    assign w_accept    = |w_grant;
    assign w_sel       = w_grant[1];

    assign w_sel_addr   = w_sel ? s_cmd_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                : s_cmd_addr[0 +: ADDR_WIDTH];
    assign w_sel_rd_wrn = w_sel ? s_cmd_rd_wrn[1] : s_cmd_rd_wrn[0];
    assign w_sel_be     = w_sel ? s_cmd_be[BE_WIDTH +: BE_WIDTH]
                                : s_cmd_be[0 +: BE_WIDTH];
    assign w_sel_wdata  = w_sel ? s_cmd_wdata[DATA_WIDTH +: DATA_WIDTH]
                                : s_cmd_wdata[0 +: DATA_WIDTH];

    assign w_push = w_accept && w_sel_rd_wrn;

    // ------------------------------------------------------------------------
    // Read return: memory answers in issue order, so the FIFO head owns the beat
    // ------------------------------------------------------------------------
    assign w_head     = r_tag_mem[r_rd_ptr[c_idx_w-1:0]];
    assign s_rd_data  = m_rd_data;
    assign s_rd_valid = (m_rd_valid && !w_empty) ? (w_head ? 2'b10 : 2'b01) : 2'b00;
    assign m_rd_ready = !w_empty && s_rd_ready[w_head];
    assign w_pop      = m_rd_valid && m_rd_ready;

    // ------------------------------------------------------------------------
    // Output command register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_rd_wrn <= 1'b0;
            r_cmd_be     <= '0;
            r_cmd_wdata  <= '0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_cmd_valid  <= 1'b1;
            r_cmd_addr   <= w_sel_addr;
            r_cmd_rd_wrn <= w_sel_rd_wrn;
            r_cmd_be     <= w_sel_be;
            r_cmd_wdata  <= w_sel_wdata;
            r_last_grant <= w_sel;
        end else if (w_out_free) begin
            r_cmd_valid  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Tag FIFO pointers and unexpected-data flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_err_unexp_rd <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (m_rd_valid && w_empty) begin
                r_err_unexp_rd <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk_core) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr[c_idx_w-1:0]] <= w_sel;
        end
    end

    assign m_cmd_valid      = r_cmd_valid;
    assign m_cmd_addr       = r_cmd_addr;
    assign m_cmd_rd_wrn     = r_cmd_rd_wrn;
    assign m_cmd_be         = r_cmd_be;
    assign m_cmd_wdata      = r_cmd_wdata;
    assign o_rd_outstanding = c_cnt_w'(w_count);
    assign o_err_unexp_rd   = r_err_unexp_rd;

endmodule
`default_nettype wire

// File: tb/tb_mem_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_cmd_arbiter
// Description : Randomized bench for mem_cmd_arbiter against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_cmd_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int RD = 8;
    localparam int NCYC = 6000;

    logic              clk_core = 1'b0;
    logic              rst;
    logic [1:0]        s_cmd_valid;
    logic [1:0]        s_cmd_ready;
    logic [2*AW-1:0]   s_cmd_addr;
    logic [1:0]        s_cmd_rd_wrn;
    logic [2*BW-1:0]   s_cmd_be;
    logic [2*DW-1:0]   s_cmd_wdata;
    logic [1:0]        s_rd_valid;
    logic [1:0]        s_rd_ready;
    logic [DW-1:0]     s_rd_data;
    logic              m_cmd_valid;
    logic              m_cmd_ready;
    logic [AW-1:0]     m_cmd_addr;
    logic              m_cmd_rd_wrn;
    logic [BW-1:0]     m_cmd_be;
    logic [DW-1:0]     m_cmd_wdata;
    logic              m_rd_valid;
    logic              m_rd_ready;
    logic [DW-1:0]     m_rd_data;
    logic [3:0]        o_rd_outstanding;
    logic              o_err_unexp_rd;

    mem_cmd_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BE_WIDTH       (BW),
        .RD_OUTSTANDING (RD)
    ) dut (
        .clk_core         (clk_core),
        .rst              (rst),
        .s_cmd_valid      (s_cmd_valid),
        .s_cmd_ready      (s_cmd_ready),
        .s_cmd_addr       (s_cmd_addr),
        .s_cmd_rd_wrn     (s_cmd_rd_wrn),
        .s_cmd_be         (s_cmd_be),
        .s_cmd_wdata      (s_cmd_wdata),
        .s_rd_valid       (s_rd_valid),
        .s_rd_ready       (s_rd_ready),
        .s_rd_data        (s_rd_data),
        .m_cmd_valid      (m_cmd_valid),
        .m_cmd_ready      (m_cmd_ready),
        .m_cmd_addr       (m_cmd_addr),
        .m_cmd_rd_wrn     (m_cmd_rd_wrn),
        .m_cmd_be         (m_cmd_be),
        .m_cmd_wdata      (m_cmd_wdata),
        .m_rd_valid       (m_rd_valid),
        .m_rd_ready       (m_rd_ready),
        .m_rd_data        (m_rd_data),
        .o_rd_outstanding (o_rd_outstanding),
        .o_err_unexp_rd   (o_err_unexp_rd)
    );

    always #5 clk_core = ~clk_core;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Reference model state: the output slot, the arbitration memory and a
    // queue holding the owning port of every read still awaiting data.
    logic          mdl_valid;
    logic [AW-1:0] mdl_addr;
    logic          mdl_rd_wrn;
    logic [BW-1:0] mdl_be;
    logic [DW-1:0] mdl_wdata;
    int            mdl_last;
    logic          mdl_err;
    int            tagq[$];

    logic [1:0]    exp_grant;
    logic [1:0]    exp_rd_valid;
    logic          exp_rd_ready;
    logic          slot_free;
    logic          full;
    logic [1:0]    elig;
    int            head;
    int            win;
    int            phase;
    int            ret_pct;
    int            n_win_p0;
    int            n_win_p1;
    int            n_full_block;

    task automatic model_reset();
        mdl_valid  = 1'b0;
        mdl_addr   = '0;
        mdl_rd_wrn = 1'b0;
        mdl_be     = '0;
        mdl_wdata  = '0;
        mdl_last   = 1;
        mdl_err    = 1'b0;
        tagq.delete();
    endtask

    initial begin
        rst          = 1'b1;
        s_cmd_valid  = '0;
        s_cmd_addr   = '0;
        s_cmd_rd_wrn = '0;
        s_cmd_be     = '0;
        s_cmd_wdata  = '0;
        s_rd_ready   = '0;
        m_cmd_ready  = 1'b0;
        m_rd_valid   = 1'b0;
        m_rd_data    = '0;
        n_win_p0     = 0;
        n_win_p1     = 0;
        n_full_block = 0;
        model_reset();
        repeat (2) @(posedge clk_core);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk_core);
            #1;
            // Phases alternate slow and fast read return so the FIFO both fills and drains.
            phase   = (cyc / 400) % 3;
            ret_pct = (phase == 0) ? 8 : ((phase == 1) ? 70 : 35);

            rst          = (cyc > 20) && ($urandom_range(0, 499) == 0);
            s_cmd_valid  = {($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70)};
            s_cmd_rd_wrn = {($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 60)};
            s_cmd_addr   = {$urandom, $urandom};
            s_cmd_be     = 16'($urandom);
            s_cmd_wdata  = {$urandom, $urandom, $urandom, $urandom};
            s_rd_ready   = {($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 80)};
            m_cmd_ready  = ($urandom_range(0, 99) < 75);
            m_rd_data    = {$urandom, $urandom};
            if (tagq.size() > 0)
                m_rd_valid = ($urandom_range(0, 99) < ret_pct);
            else
                m_rd_valid = ($urandom_range(0, 299) == 0);

            #3;
            // Expected combinational behaviour from the current model state.
            slot_free = !mdl_valid || m_cmd_ready;
            full      = (tagq.size() >= RD);
            elig[0]   = s_cmd_valid[0] && (!s_cmd_rd_wrn[0] || !full);
            elig[1]   = s_cmd_valid[1] && (!s_cmd_rd_wrn[1] || !full);
            win       = -1;
            if (slot_free) begin
                if (elig[0] && elig[1]) win = 1 - mdl_last;
                else if (elig[0])       win = 0;
                else if (elig[1])       win = 1;
            end
            exp_grant = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
            head      = (tagq.size() > 0) ? tagq[0] : 0;
            exp_rd_valid = 2'b00;
            if (m_rd_valid && tagq.size() > 0)
                exp_rd_valid = (head == 1) ? 2'b10 : 2'b01;
            exp_rd_ready = (tagq.size() > 0) && s_rd_ready[head];

            check_eq("s_cmd_ready", 64'(s_cmd_ready), 64'(exp_grant));
            check_eq("m_cmd_valid", 64'(m_cmd_valid), 64'(mdl_valid));
            check_eq("m_cmd_addr", 64'(m_cmd_addr), 64'(mdl_addr));
            check_eq("m_cmd_rd_wrn", 64'(m_cmd_rd_wrn), 64'(mdl_rd_wrn));
            check_eq("m_cmd_be", 64'(m_cmd_be), 64'(mdl_be));
            check_eq("m_cmd_wdata", 64'(m_cmd_wdata), 64'(mdl_wdata));
            check_eq("s_rd_valid", 64'(s_rd_valid), 64'(exp_rd_valid));
            check_eq("m_rd_ready", 64'(m_rd_ready), 64'(exp_rd_ready));
            check_eq("s_rd_data", 64'(s_rd_data), 64'(m_rd_data));
            check_eq("rd_outstanding", 64'(o_rd_outstanding), 64'(tagq.size()));
            check_eq("err_unexp_rd", 64'(o_err_unexp_rd), 64'(mdl_err));

            if (win == 0) n_win_p0++;
            if (win == 1) n_win_p1++;
            if (full && (s_cmd_valid & s_cmd_rd_wrn) != 2'b00) n_full_block++;

            // Advance the model to the state after the coming clock edge.
            if (rst) begin
                model_reset();
            end else begin
                if (m_rd_valid && tagq.size() == 0) mdl_err = 1'b1;
                if (m_rd_valid && exp_rd_ready) void'(tagq.pop_front());
                if (win >= 0) begin
                    mdl_valid  = 1'b1;
                    mdl_addr   = (win == 1) ? s_cmd_addr[2*AW-1:AW] : s_cmd_addr[AW-1:0];
                    mdl_rd_wrn = s_cmd_rd_wrn[win];
                    mdl_be     = (win == 1) ? s_cmd_be[2*BW-1:BW] : s_cmd_be[BW-1:0];
                    mdl_wdata  = (win == 1) ? s_cmd_wdata[2*DW-1:DW] : s_cmd_wdata[DW-1:0];
                    mdl_last   = win;
                    if (s_cmd_rd_wrn[win]) tagq.push_back(win);
                end else if (slot_free) begin
                    mdl_valid = 1'b0;
                end
            end
        end

        // Stimulus must have exercised both ports and the full-FIFO hold-off.
        check_eq("p0_granted", 64'(n_win_p0 > 0), 64'd1);
        check_eq("p1_granted", 64'(n_win_p1 > 0), 64'd1);
        check_eq("full_blocked", 64'(n_full_block > 0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
